// File: rtl/clock_freq_monitor_if.sv
// -----------------------------------------------------------------------------
// clock_freq_monitor_if
// Control and result bundle of the clock frequency monitor.
//   en          : measurement enable (clk domain)
//   limit_min   : inclusive lower bound of the accepted count window
//   limit_max   : inclusive upper bound of the accepted count window
//   count_out   : edge count of the last reported gate window
//   count_valid : one-cycle pulse when count_out/in_range/stopped update
//   in_range    : last reported count was within [limit_min, limit_max]
//   stopped     : last reported window contained no edges
//   locked      : enough consecutive in-range windows have been seen
// master = controlling side (drives en and limits), slave = the monitor.
// -----------------------------------------------------------------------------
interface clock_freq_monitor_if #(
  parameter int COUNT_WIDTH = 24
);
  logic                   en;
  logic [COUNT_WIDTH-1:0] limit_min;
  logic [COUNT_WIDTH-1:0] limit_max;
  logic [COUNT_WIDTH-1:0] count_out;
  logic                   count_valid;
  logic                   in_range;
  logic                   stopped;
  logic                   locked;

  modport master (
    output en,
    output limit_min,
    output limit_max,
    input  count_out,
    input  count_valid,
    input  in_range,
    input  stopped,
    input  locked
  );

  modport slave (
    input  en,
    input  limit_min,
    input  limit_max,
    output count_out,
    output count_valid,
    output in_range,
    output stopped,
    output locked
  );
endinterface

// File: rtl/clock_freq_monitor.sv
// -----------------------------------------------------------------------------
// clock_freq_monitor
// Measures the frequency of a returned clock using clk as the timebase. An
// external prescaler in the measured domain flips meas_toggle once every N
// measured cycles; this block synchronizes that toggle, counts its edges over
// a fixed gate window of GATE_CYCLES clk cycles and reports the count together
// with in-range, stopped and locked status.
// Ports:
//   clk          : system clock / timebase
//   rst_n        : asynchronous active-low reset
//   meas_toggle  : asynchronous toggle from the measured-domain prescaler
//   mon          : control/result bundle (slave side), see clock_freq_monitor_if
// Operation: after enable, one priming window is measured and discarded, then
// windows run back to back and each one is reported with a single-cycle
// count_valid pulse one cycle after its final gate cycle.
// -----------------------------------------------------------------------------
module clock_freq_monitor #(
  parameter int GATE_CYCLES  = 156250,
  parameter int COUNT_WIDTH  = 24,
  parameter int LOCK_WINDOWS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  meas_toggle,
  clock_freq_monitor_if.slave   mon
);

  localparam int                     GATE_W      = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]      GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]      GATE_ONE    = GATE_W'(1'b1);
  localparam logic [GATE_W-1:0]      GATE_ZERO   = {GATE_W{1'b0}};
  localparam int                     LOCK_W      = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LOCK_W-1:0]      LOCK_TARGET = LOCK_W'(LOCK_WINDOWS);
  localparam logic [LOCK_W-1:0]      LOCK_ONE    = LOCK_W'(1'b1);
  localparam logic [LOCK_W-1:0]      LOCK_ZERO   = {LOCK_W{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1'b1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO  = {COUNT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Saturating increment: the edge counter must stick at all-ones, never wrap.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] value,
    input logic                   inc
  );
    logic [COUNT_WIDTH-1:0] result;
    if (inc && (value != COUNT_MAX)) begin
      result = value + COUNT_ONE;
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_e                 state_q,       state_d;
  logic [SYNC_STAGES-1:0] sync_q,        sync_d;
  logic                   sync_prev_q,   sync_prev_d;
  logic [GATE_W-1:0]      gate_q,        gate_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q,    edge_cnt_d;
  logic [LOCK_W-1:0]      lock_cnt_q,    lock_cnt_d;
  logic [COUNT_WIDTH-1:0] count_out_q,   count_out_d;
  logic                   count_valid_q, count_valid_d;
  logic                   in_range_q,    in_range_d;
  logic                   stopped_q,     stopped_d;
  logic                   locked_q,      locked_d;

  logic                   edge_s;
  logic                   last_cycle_s;
  logic                   in_range_s;
  logic [COUNT_WIDTH-1:0] count_next_s;

  // Next-state logic: synchronizer shift, gate/edge counters, FSM and report.
  always_comb begin
    // Synchronizer and edge detect run regardless of enable.
    sync_d       = {sync_q[SYNC_STAGES-2:0], meas_toggle};
    sync_prev_d  = sync_q[SYNC_STAGES-1];
    edge_s       = sync_q[SYNC_STAGES-1] ^ sync_prev_q;

    // Count including this cycle's edge, so an edge in the final gate cycle
    // lands in the window that is ending.
    count_next_s = sat_inc(edge_cnt_q, edge_s);
    last_cycle_s = (gate_q == GATE_LAST);
    // Reversed limits make this false for every count, as intended.
    in_range_s   = (count_next_s >= mon.limit_min) && (count_next_s <= mon.limit_max);

    state_d       = state_q;
    gate_d        = gate_q;
    edge_cnt_d    = edge_cnt_q;
    lock_cnt_d    = lock_cnt_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    in_range_d    = in_range_q;
    stopped_d     = stopped_q;
    locked_d      = locked_q;

    if (!mon.en) begin
      // Abort: drop everything except the last reported count.
      state_d    = ST_IDLE;
      gate_d     = GATE_ZERO;
      edge_cnt_d = COUNT_ZERO;
      lock_cnt_d = LOCK_ZERO;
      in_range_d = 1'b0;
      stopped_d  = 1'b0;
      locked_d   = 1'b0;
    end else begin
      // The enabling cycle already counts as gate cycle 0 of the priming
      // window (gate and edge counters are zero in IDLE).
      if (last_cycle_s) begin
        gate_d     = GATE_ZERO;
        edge_cnt_d = COUNT_ZERO;
      end else begin
        gate_d     = gate_q + GATE_ONE;
        edge_cnt_d = count_next_s;
      end

      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
        end
        ST_PRIME: begin
          // Priming result is discarded; it swallows any spurious edge
          // produced by the toggle source starting up.
          if (last_cycle_s) begin
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_PRIME;
          end
        end
        ST_MEASURE: begin
          state_d = ST_MEASURE;
          if (last_cycle_s) begin
            count_out_d   = count_next_s;
            count_valid_d = 1'b1;
            stopped_d     = (count_next_s == COUNT_ZERO);
            in_range_d    = in_range_s;
            if (in_range_s) begin
              lock_cnt_d = (lock_cnt_q == LOCK_TARGET) ? lock_cnt_q : (lock_cnt_q + LOCK_ONE);
              locked_d   = (lock_cnt_d == LOCK_TARGET);
            end else begin
              lock_cnt_d = LOCK_ZERO;
              locked_d   = 1'b0;
            end
          end else begin
            count_valid_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          gate_d     = GATE_ZERO;
          edge_cnt_d = COUNT_ZERO;
        end
      endcase
    end
  end

  // State registers, including the FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync_q        <= {SYNC_STAGES{1'b0}};
      sync_prev_q   <= 1'b0;
      gate_q        <= GATE_ZERO;
      edge_cnt_q    <= COUNT_ZERO;
      lock_cnt_q    <= LOCK_ZERO;
      count_out_q   <= COUNT_ZERO;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      stopped_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      sync_prev_q   <= sync_prev_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      stopped_q     <= stopped_d;
      locked_q      <= locked_d;
    end
  end

  assign mon.count_out   = count_out_q;
  assign mon.count_valid = count_valid_q;
  assign mon.in_range    = in_range_q;
  assign mon.stopped     = stopped_q;
  assign mon.locked      = locked_q;

endmodule

// File: tb/tb_clock_freq_monitor.sv
module tb_clock_freq_monitor;

  localparam int G   = 100;
  localparam int CW  = 8;
  localparam int CW6 = 6;
  localparam int LW  = 4;

  logic clk;
  logic rst_n;
  logic meas_toggle;
  logic tog6;

  int tog_period;
  int flip_req;
  int n_checks;
  int n_errors;

  clock_freq_monitor_if #(.COUNT_WIDTH(CW))  mon_if ();
  clock_freq_monitor_if #(.COUNT_WIDTH(CW6)) mon6_if ();

  clock_freq_monitor #(
    .GATE_CYCLES(G), .COUNT_WIDTH(CW), .LOCK_WINDOWS(LW), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .meas_toggle(meas_toggle), .mon(mon_if)
  );

  clock_freq_monitor #(
    .GATE_CYCLES(G), .COUNT_WIDTH(CW6), .LOCK_WINDOWS(LW), .SYNC_STAGES(2)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .meas_toggle(tog6), .mon(mon6_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Toggle sources: periodic prescaler model plus single forced flips.
  initial begin
    int cnt;
    int done;
    cnt = 0;
    done = 0;
    meas_toggle = 1'b0;
    tog6 = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tog6 = ~tog6;
      if (flip_req != done) begin
        meas_toggle = ~meas_toggle;
        done = flip_req;
        cnt = 0;
      end else if (tog_period == 0) begin
        cnt = 0;
      end else if (cnt >= tog_period - 1) begin
        meas_toggle = ~meas_toggle;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Reference model: a toggle change is seen as an edge three cycles later;
  // windows are fixed 100-cycle slices measured from the cycle enable rose,
  // the first slice is discarded, every later slice is reported.
  logic       h1, h2, h3;
  int         run_len, win_sum, consec;
  logic [7:0] m_count;
  logic       m_valid, m_inr, m_stop, m_lock;

  always @(posedge clk) begin
    logic t;
    logic d;
    int   c;
    if (rst_n !== 1'b1) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      run_len = 0; win_sum = 0; consec = 0;
      m_count = 8'd0; m_valid = 1'b0; m_inr = 1'b0; m_stop = 1'b0; m_lock = 1'b0;
    end else begin
      t = meas_toggle;
      d = h2 ^ h3;
      h3 = h2; h2 = h1; h1 = t;
      if (mon_if.en !== 1'b1) begin
        run_len = 0; win_sum = 0; consec = 0;
        m_valid = 1'b0; m_inr = 1'b0; m_stop = 1'b0; m_lock = 1'b0;
      end else begin
        m_valid = 1'b0;
        win_sum += int'(d);
        if ((run_len % G) == G - 1) begin
          if (run_len >= 2 * G - 1) begin
            c = (win_sum > 255) ? 255 : win_sum;
            m_count = 8'(c);
            m_valid = 1'b1;
            m_stop  = (c == 0);
            m_inr   = (c >= int'(mon_if.limit_min)) && (c <= int'(mon_if.limit_max));
            if (m_inr) consec = (consec < LW) ? consec + 1 : LW;
            else consec = 0;
            m_lock = (consec >= LW);
          end
          win_sum = 0;
        end
        run_len++;
      end
    end
  end

  wire [11:0] got_w = {mon_if.count_valid, mon_if.in_range, mon_if.stopped, mon_if.locked, mon_if.count_out};
  wire [11:0] exp_w = {m_valid, m_inr, m_stop, m_lock, m_count};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to following negedges, comparing against the model each cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n === 1'b1) check("model_cycle", got_w, exp_w);
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles, output bit found);
    found = 1'b0;
    cycles = 0;
    while (!found && cycles < limit) begin
      tick(1);
      cycles++;
      if (mon_if.count_valid === 1'b1) found = 1'b1;
    end
    check("valid_seen", found, 1'b1);
  endtask

  typedef struct packed {
    int period;
    int lmin;
    int lmax;
    int exp_count;
    int exp_inr;
    int exp_stop;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   cyc;
    bit   found;
    bit   found25;
    int   cons;
    int   nvalid;
    int   nlock;
    int   mode;

    vecs[0] = '{period: 5,  lmin: 18, lmax: 22, exp_count: 20, exp_inr: 1, exp_stop: 0};
    vecs[1] = '{period: 4,  lmin: 18, lmax: 22, exp_count: 25, exp_inr: 0, exp_stop: 0};
    vecs[2] = '{period: 0,  lmin: 18, lmax: 22, exp_count: 0,  exp_inr: 0, exp_stop: 1};
    vecs[3] = '{period: 0,  lmin: 0,  lmax: 0,  exp_count: 0,  exp_inr: 1, exp_stop: 1};
    vecs[4] = '{period: 5,  lmin: 22, lmax: 18, exp_count: 20, exp_inr: 0, exp_stop: 0};
    vecs[5] = '{period: 10, lmin: 10, lmax: 10, exp_count: 10, exp_inr: 1, exp_stop: 0};

    n_checks = 0;
    n_errors = 0;
    tog_period = 0;
    flip_req = 0;
    rst_n = 1'b0;
    mon_if.en = 1'b0;
    mon_if.limit_min = 8'd0;
    mon_if.limit_max = 8'd0;
    mon6_if.en = 1'b0;
    mon6_if.limit_min = 6'd0;
    mon6_if.limit_max = 6'd0;

    tick(4);
    check("reset_outputs", got_w, 12'h000);
    check("reset_outputs6", {mon6_if.count_valid, mon6_if.in_range, mon6_if.stopped,
                             mon6_if.locked, mon6_if.count_out}, 10'h000);
    rst_n = 1'b1;
    tick(2);

    // Table: steady toggle rates against limits.
    for (int v = 0; v < 6; v++) begin
      mon_if.en = 1'b0;
      tog_period = vecs[v].period;
      mon_if.limit_min = 8'(vecs[v].lmin);
      mon_if.limit_max = 8'(vecs[v].lmax);
      tick(3);
      mon_if.en = 1'b1;
      wait_valid(250, cyc, found);
      check("first_latency", cyc, 200);
      for (int w = 0; w < 2; w++) begin
        if (w == 1) begin
          wait_valid(150, cyc, found);
          check("window_period", cyc, 100);
        end
        check("vec_count", mon_if.count_out, vecs[v].exp_count);
        check("vec_in_range", mon_if.in_range, vecs[v].exp_inr);
        check("vec_stopped", mon_if.stopped, vecs[v].exp_stop);
      end
    end

    // Lock acquisition, loss on a faster clock, and re-lock.
    mon_if.en = 1'b0;
    tog_period = 5;
    mon_if.limit_min = 8'd18;
    mon_if.limit_max = 8'd22;
    tick(3);
    mon_if.en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wait_valid(250, cyc, found);
      check("lock_rise", mon_if.locked, (k >= LW));
    end
    tog_period = 4;
    found25 = 1'b0;
    for (int k = 0; k < 5 && !found25; k++) begin
      wait_valid(150, cyc, found);
      if (mon_if.in_range !== 1'b1) check("lock_drop", mon_if.locked, 1'b0);
      if (mon_if.count_out === 8'd25) begin
        found25 = 1'b1;
        check("fast_in_range", mon_if.in_range, 1'b0);
        check("fast_locked", mon_if.locked, 1'b0);
      end
    end
    check("saw_count_25", found25, 1'b1);
    tog_period = 5;
    cons = 0;
    for (int k = 0; k < 10 && cons < 5; k++) begin
      wait_valid(150, cyc, found);
      if (mon_if.in_range === 1'b1) cons++;
      else cons = 0;
      check("relock", mon_if.locked, (cons >= LW));
    end
    wait_valid(150, cyc, found);
    check("steady_count", mon_if.count_out, 20);

    // Abort with en low mid-window; count_out holds, status clears.
    tick(50);
    mon_if.en = 1'b0;
    tick(1);
    check("abort_status", {mon_if.count_valid, mon_if.in_range, mon_if.stopped, mon_if.locked}, 4'h0);
    check("abort_count_held", mon_if.count_out, 20);
    nvalid = 0;
    for (int i = 0; i < 150; i++) begin
      tick(1);
      if (mon_if.count_valid === 1'b1) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    mon_if.en = 1'b1;
    wait_valid(250, cyc, found);
    check("reenable_latency", cyc, 200);

    // Asynchronous reset mid-window.
    tick(30);
    rst_n = 1'b0;
    #1;
    check("rst_clear", got_w, 12'h000);
    tick(3);
    rst_n = 1'b1;
    wait_valid(250, cyc, found);
    check("post_rst_latency", cyc, 200);
    check("post_rst_count", mon_if.count_out, 20);

    // Enable chattering every cycle never produces a report.
    nvalid = 0;
    nlock = 0;
    for (int i = 0; i < 40; i++) begin
      mon_if.en = ~mon_if.en;
      tick(1);
      if (mon_if.count_valid === 1'b1) nvalid++;
      if (mon_if.locked === 1'b1) nlock++;
    end
    check("chatter_no_valid", nvalid, 0);
    check("chatter_no_lock", nlock, 0);

    // Edges in the final window cycle and the first cycle of the next one.
    mon_if.en = 1'b0;
    tog_period = 0;
    tick(5);
    mon_if.en = 1'b1;
    tick(197);
    flip_req++;
    tick(1);
    flip_req++;
    tick(2);
    check("edge_last_valid", mon_if.count_valid, 1'b1);
    check("edge_last_count", mon_if.count_out, 1);
    tick(100);
    check("edge_next_valid", mon_if.count_valid, 1'b1);
    check("edge_next_count", mon_if.count_out, 1);

    // Saturation on the 6-bit instance with a toggle every clk.
    mon6_if.limit_min = 6'd60;
    mon6_if.limit_max = 6'd63;
    mon6_if.en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      found = 1'b0;
      cyc = 0;
      while (!found && cyc < 300) begin
        tick(1);
        cyc++;
        if (mon6_if.count_valid === 1'b1) found = 1'b1;
      end
      check("sat_seen", found, 1'b1);
      check("sat_count", mon6_if.count_out, 63);
      check("sat_in_range", mon6_if.in_range, 1'b1);
    end
    mon6_if.en = 1'b0;

    // Randomized segments against the model.
    for (int seg = 0; seg < 24; seg++) begin
      mode = int'($urandom_range(0, 9));
      tog_period = int'($urandom_range(0, 10));
      mon_if.limit_min = 8'($urandom_range(5, 25));
      mon_if.limit_max = 8'(int'(mon_if.limit_min) + int'($urandom_range(0, 8)) - 2);
      if (mode < 7) begin
        mon_if.en = 1'b1;
        tick(int'($urandom_range(50, 600)));
        if ($urandom_range(0, 1) == 1) begin
          tog_period = int'($urandom_range(1, 10));
          tick(int'($urandom_range(100, 400)));
        end
        mon_if.en = 1'($urandom_range(0, 1));
        tick(2);
      end else if (mode < 9) begin
        for (int i = 0; i < 20; i++) begin
          mon_if.en = ~mon_if.en;
          tick(1);
        end
      end else begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
